// File: rtl/dm_slave_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dm_slave_arbiter_pkg
// Shared debug-module constants: port identifiers used by the slave-port
// arbiter and the default debug-memory window (also used by the DM top).
// -----------------------------------------------------------------------------
package dm_slave_arbiter_pkg;
   localparam logic        PORT_I       = 1'b0;   // instruction-fetch port
   localparam logic        PORT_D       = 1'b1;   // data port
   localparam logic [31:0] DM_BASE_ADDR = 32'h0000_1000;
   localparam logic [31:0] DM_SPAN      = 32'h0000_1000;
endpackage

// File: rtl/dm_rr_arb2.sv
// -----------------------------------------------------------------------------
// dm_rr_arb2
// Two-way round-robin grant. A lone requester always wins; on contention the
// port that was NOT granted last wins. The pointer holds the last granted port
// and resets to PORT_I, so the data port wins the first contended cycle.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_en          grant enable (low during flush/reset)
//   i_req[1:0]    requests, indexed by PORT_I / PORT_D
//   o_gnt_vld     a port is granted this cycle
//   o_gnt_port    granted port (valid with o_gnt_vld)
// -----------------------------------------------------------------------------
module dm_rr_arb2
   import dm_slave_arbiter_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic       o_gnt_vld,
   output logic       o_gnt_port
);
   logic r_rr;   // last granted port

   always_comb begin
      o_gnt_vld  = i_en && (|i_req);
      o_gnt_port = PORT_I;
      if (i_req == 2'b11)      o_gnt_port = ~r_rr;
      else if (i_req[PORT_D])  o_gnt_port = PORT_D;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)          r_rr <= PORT_I;
      else if (o_gnt_vld) r_rr <= o_gnt_port;
   end
endmodule

// File: rtl/dm_slave_arbiter.sv
// -----------------------------------------------------------------------------
// dm_slave_arbiter
// Shares the debug module's single memory slave port between the core's
// instruction-fetch and data ports. Requests are acknowledged in the same
// cycle; responses come back exactly one cycle later to the issuing port.
// Out-of-window requests are acknowledged but never reach the slave; they
// return rdata 0 (plus d_err_o on the data port).
// Ports:
//   clk_i, rst_i, flush_i            clock, sync reset, ndmreset flush
//   i_req_i/i_addr_i                 instruction request (read-only)
//   i_ready_o/i_rvalid_o/i_rdata_o   instruction accept / response
//   d_req_i/d_we_i/d_addr_i/d_wdata_i/d_be_i   data request
//   d_ready_o/d_rvalid_o/d_rdata_o/d_err_o     data accept / response
//   slave_*                          shared debug-memory slave port
// -----------------------------------------------------------------------------
module dm_slave_arbiter
   import dm_slave_arbiter_pkg::*;
#(
   parameter int unsigned            BusWidth      = 32,
   parameter logic [BusWidth-1:0]    DmBaseAddress = BusWidth'(DM_BASE_ADDR),
   parameter logic [BusWidth-1:0]    DmSpan        = BusWidth'(DM_SPAN)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    flush_i,
   input  logic                    i_req_i,
   input  logic [BusWidth-1:0]     i_addr_i,
   output logic                    i_ready_o,
   output logic                    i_rvalid_o,
   output logic [BusWidth-1:0]     i_rdata_o,
   input  logic                    d_req_i,
   input  logic                    d_we_i,
   input  logic [BusWidth-1:0]     d_addr_i,
   input  logic [BusWidth-1:0]     d_wdata_i,
   input  logic [BusWidth/8-1:0]   d_be_i,
   output logic                    d_ready_o,
   output logic                    d_rvalid_o,
   output logic [BusWidth-1:0]     d_rdata_o,
   output logic                    d_err_o,
   output logic                    slave_req_o,
   output logic                    slave_we_o,
   output logic [BusWidth-1:0]     slave_addr_o,
   output logic [BusWidth-1:0]     slave_wdata_o,
   output logic [BusWidth/8-1:0]   slave_be_o,
   input  logic [BusWidth-1:0]     slave_rdata_i
);
   // Window end is one bit wider so a window reaching 2^BusWidth cannot wrap.
   localparam logic [BusWidth:0] WIN_END = {1'b0, DmBaseAddress} + {1'b0, DmSpan};

   logic                r_pend;   // response due this cycle
   logic                r_own;    // owner of that response
   logic                r_err;    // that response is an out-of-window error

   logic                w_en;
   logic                w_gnt_vld;
   logic                w_gnt_port;
   logic [BusWidth-1:0] w_sel_addr;
   logic                w_in_win;
   logic                w_rsp;
   logic [BusWidth-1:0] w_rsp_data;

   assign w_en = !rst_i && !flush_i;

   dm_rr_arb2 u_arb (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_en       (w_en),
      .i_req      ({d_req_i, i_req_i}),
      .o_gnt_vld  (w_gnt_vld),
      .o_gnt_port (w_gnt_port)
   );

   assign w_sel_addr = (w_gnt_port == PORT_D) ? d_addr_i : i_addr_i;
   assign w_in_win   = ({1'b0, w_sel_addr} >= {1'b0, DmBaseAddress}) &&
                       ({1'b0, w_sel_addr} <  WIN_END);

   assign i_ready_o  = w_gnt_vld && (w_gnt_port == PORT_I);
   assign d_ready_o  = w_gnt_vld && (w_gnt_port == PORT_D);

   // Only in-window grants reach the slave; everything else parks at zero.
   always_comb begin
      slave_req_o   = 1'b0;
      slave_we_o    = 1'b0;
      slave_addr_o  = '0;
      slave_wdata_o = '0;
      slave_be_o    = '0;
      if (w_gnt_vld && w_in_win) begin
         slave_req_o  = 1'b1;
         slave_addr_o = w_sel_addr;
         if (w_gnt_port == PORT_D) begin
            slave_we_o    = d_we_i;
            slave_wdata_o = d_wdata_i;
            slave_be_o    = d_be_i;
         end else begin
            slave_be_o    = '1;
         end
      end
   end

   // Flush and reset suppress a response that is due in the current cycle.
   assign w_rsp      = r_pend && w_en;
   assign w_rsp_data = r_err ? '0 : slave_rdata_i;

   assign i_rvalid_o = w_rsp && (r_own == PORT_I);
   assign d_rvalid_o = w_rsp && (r_own == PORT_D);
   assign i_rdata_o  = i_rvalid_o ? w_rsp_data : '0;
   assign d_rdata_o  = d_rvalid_o ? w_rsp_data : '0;
   assign d_err_o    = d_rvalid_o && r_err;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pend <= 1'b0;
         r_own  <= PORT_I;
         r_err  <= 1'b0;
      end else begin
         // No grant (including flush) clears pend/err.
         r_pend <= w_gnt_vld;
         r_err  <= w_gnt_vld && !w_in_win;
         if (w_gnt_vld) r_own <= w_gnt_port;
      end
   end
endmodule
